// File: rtl/sram_byte_arbiter_if.sv
// Bus bundle between two byte-wide requesters (A, B), the arbiter, and port 0 of the
// 32x512 SRAM macro. The arbiter uses the slave view; the tile/SRAM environment uses master.
interface sram_byte_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [10:0] a_addr;
    logic [7:0]  a_wdata;
    logic        a_ack;
    logic [7:0]  a_rdata;

    logic        b_req;
    logic        b_we;
    logic [10:0] b_addr;
    logic [7:0]  b_wdata;
    logic        b_ack;
    logic [7:0]  b_rdata;

    logic        ram_clk0;
    logic        ram_csb0;
    logic        ram_web0;
    logic [3:0]  ram_wmask0;
    logic [8:0]  ram_addr0;
    logic [31:0] ram_din0;
    logic [31:0] ram_dout0;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  ram_clk0, ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0,
        output ram_dout0
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output ram_clk0, ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0,
        input  ram_dout0
    );
endinterface

// File: rtl/sram_byte_arbiter.sv
// Round-robin arbiter sharing SRAM port 0 between two byte requesters; converts byte
// addresses to word address + lane, masking lanes on writes and extracting them on reads.
module sram_byte_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    sram_byte_arbiter_if.slave bus,
    output logic [1:0]         dbg_state
);

    // Handshake: a requester raises req with we/addr/wdata stable and holds them until its
    // one-cycle ack; req is sampled only in IDLE, so a request still high during ack is
    // treated as the next access, whose fields must already be updated by then.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

    state_t      state;
    state_t      state_nxt;

    logic        grant;
    logic        pick_b;
    logic        sel_we;
    logic [10:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic [7:0]  rd_byte;

    logic        own_b;
    logic        last_b;
    logic        we_q;
    logic [1:0]  lane_q;
    logic [1:0]  cnt;

    assign bus.ram_clk0 = clk;
    assign dbg_state    = state;

    always_comb begin
        grant     = bus.a_req | bus.b_req;
        // On contention the requester that did not win last time goes first.
        pick_b    = bus.b_req & (~bus.a_req | ~last_b);
        sel_we    = pick_b ? bus.b_we    : bus.a_we;
        sel_addr  = pick_b ? bus.b_addr  : bus.a_addr;
        sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
        rd_byte   = bus.ram_dout0[{lane_q, 3'b000} +: 8];

        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_q ? ACK : RDWAIT;
            RDWAIT:  if (cnt == CNT_LAST) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ram_csb0   <= 1'b1;
            bus.ram_web0   <= 1'b1;
            bus.ram_wmask0 <= 4'b0000;
            bus.ram_addr0  <= 9'd0;
            bus.ram_din0   <= 32'd0;
            bus.a_ack      <= 1'b0;
            bus.b_ack      <= 1'b0;
            bus.a_rdata    <= 8'd0;
            bus.b_rdata    <= 8'd0;
            own_b          <= 1'b0;
            last_b         <= 1'b1;
            we_q           <= 1'b0;
            lane_q         <= 2'd0;
            cnt            <= 2'd0;
        end else begin
            bus.a_ack <= 1'b0;
            bus.b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        own_b         <= pick_b;
                        last_b        <= pick_b;
                        we_q          <= sel_we;
                        lane_q        <= sel_addr[1:0];
                        // SRAM command registered here so it is stable for the whole ISSUE cycle.
                        bus.ram_csb0  <= 1'b0;
                        bus.ram_web0  <= ~sel_we;
                        bus.ram_addr0 <= sel_addr[10:2];
                        if (sel_we) begin
                            bus.ram_wmask0 <= 4'b0001 << sel_addr[1:0];
                            bus.ram_din0   <= {4{sel_wdata}};
                        end else begin
                            bus.ram_wmask0 <= 4'b0000;
                        end
                    end
                end
                ISSUE: begin
                    bus.ram_csb0   <= 1'b1;
                    bus.ram_web0   <= 1'b1;
                    bus.ram_wmask0 <= 4'b0000;
                    cnt            <= 2'd0;
                    if (we_q) begin
                        if (own_b) bus.b_ack <= 1'b1;
                        else       bus.a_ack <= 1'b1;
                    end
                end
                RDWAIT: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == CNT_LAST) begin
                        if (own_b) begin
                            bus.b_rdata <= rd_byte;
                            bus.b_ack   <= 1'b1;
                        end else begin
                            bus.a_rdata <= rd_byte;
                            bus.a_ack   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sram_byte_arbiter.md
Name: sram_byte_arbiter

Overview:
- Shares the single read/write port (port 0) of the sky130_sram_2kbyte_1rw1r_32x512_8 macro between two byte-wide requesters, A and B.
- Arbitration is round-robin. The block sequences each access as one SRAM command cycle, then a read-wait if the access is a read, then a one-cycle ack.
- Byte addresses are converted to a word address plus lane. Writes use lane masking; reads use lane extraction.
- Sits between the tile logic and the SRAM macro, in place of a direct single-master connection.

Parameters:
- RD_LAT, 1: cycles from the SRAM command edge until ram_dout0 is sampled. Legal range 1..3.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- a_req  in  1  requester A access request; level, held until a_ack
- a_we  in  1  requester A: 1 = write, 0 = read
- a_addr  in  11  requester A byte address
- a_wdata  in  8  requester A write byte
- a_ack  out  1  requester A completion, one-cycle pulse
- a_rdata  out  8  requester A read byte
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as requester A, for requester B
- ram_clk0  out  1  SRAM clock; equals clk (combinational pass-through)
- ram_csb0  out  1  SRAM chip select, active-low
- ram_web0  out  1  SRAM write enable, active-low
- ram_wmask0  out  4  SRAM byte write mask
- ram_addr0  out  9  SRAM word address
- ram_din0  out  32  SRAM write data
- ram_dout0  in  32  SRAM read data

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Outputs: ram_csb0=1, ram_web0=1, ram_wmask0=0, ram_addr0=0, ram_din0=0, a_ack=b_ack=0, a_rdata=b_rdata=0.
  - FSM goes to IDLE; last_grant=B, so A wins the first contention.
- All outputs except ram_clk0 are registered.
- FSM states: IDLE, ISSUE, RDWAIT, ACK.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant the requester that is not last_grant.
  - On grant: latch we, lane=addr[1:0] and owner; set last_grant=owner; go to ISSUE.
- ISSUE (SRAM outputs driven for exactly this one cycle):
  - ram_csb0=0, ram_addr0=addr[10:2], ram_web0=~we.
  - Write: ram_wmask0=1<<lane, ram_din0={4{wdata}}.
  - Read: ram_wmask0=0, ram_din0 holds its previous value.
  - Next state: ACK for a write, RDWAIT for a read.
- RDWAIT:
  - Counts RD_LAT cycles.
  - On the final cycle, captures ram_dout0[8*lane +: 8] into the owner's rdata. rdata is valid from the ack cycle onward.
  - Next state: ACK.
- ACK:
  - Owner's ack=1 for exactly one cycle; ram_csb0=1, ram_web0=1.
  - Next state: IDLE unconditionally. req is not sampled in ACK, so an already-serviced request is never reissued.
- Latency from req sampled in IDLE (cycle 0):
  - Write: ack in cycle 2.
  - Read: ack in cycle 2+RD_LAT.
  - Back-to-back writes by one requester: one access per 3 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack.
  - May keep req high after ack to request the next access; the fields must be updated on the ack edge.
  - Deasserting req before ack is illegal; behaviour is undefined.
- The non-granted requester's fields are ignored. Its req stays pending and is served next.
- rdata is unchanged by writes and by the other requester's accesses. It holds until that requester's next read completes.
- Reset mid-operation (any state): pending access is dropped, no ack is issued, and ram_csb0 goes high immediately. A write whose ISSUE edge already occurred may have committed.
- Address wrap: none. The 11-bit address covers exactly 2 KB.

Test Plan:
- Reset: assert rst with random inputs -> all outputs at their reset values, including ram_csb0=1 and ram_web0=1; ram_clk0 still follows clk.
- A writes 0xA5 to 0x005 -> one ISSUE cycle with ram_addr0=1, ram_wmask0=4'b0010, ram_din0=0xA5A5A5A5, ram_web0=0; a_ack pulses 2 cycles after req.
- A writes 0x11, 0x22, 0x33, 0x44 to 0x010..0x013, then B reads 0x012 (RD_LAT=1) -> b_rdata=0x33, b_ack 3 cycles after req, a_rdata stays 0x00.
- A and B both request continuously after reset -> grants alternate A,B,A,B; each ack is a single cycle; ram_csb0 is low for exactly one cycle per access.
- rst pulsed while in ISSUE of a B read -> ram_csb0=1 immediately; no b_ack; after release, A wins the first contention.
- Only B requesting, 4 back-to-back writes -> b_ack every 3 cycles; a_ack never asserts; a_rdata unchanged.
